// File: rtl/gigex_spi_slave_if.sv
// Bundle of the SPI pins plus the command and response handshakes of the GigEx SPI slave.
// The slave modport is the block's view; the master modport is the host/fabric view.
interface gigex_spi_slave_if;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  err_count;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, cmd_ready, rsp_data, rsp_valid,
        output spi_miso, cmd_data, cmd_valid, rsp_ready, err_count
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, cmd_ready, rsp_data, rsp_valid,
        input  spi_miso, cmd_data, cmd_valid, rsp_ready, err_count
    );
endinterface

// File: rtl/gigex_spi_slave.sv
// GigEx SPI slave: oversamples the SPI pins in the clk domain, forwards 32-bit command
// frames over valid/ready and returns buffered responses on MISO in the following frame.
module gigex_spi_slave #(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    gigex_spi_slave_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;

    state_t        state;
    logic          cs_s1, cs_s2, cs_h;
    logic          sck_s1, sck_s2, sck_h;
    logic          mosi_s1, mosi_s2;
    logic [1:0]    rst_pipe;
    logic          armed;
    logic [5:0]    bit_cnt;
    logic [31:0]   rx_sr;
    logic [31:0]   tx_sr;
    logic          miso_q;
    logic [31:0]   cmd_data_q;
    logic          cmd_valid_q;
    logic [7:0]    err_q;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ready_q;

    logic          cs_fall_c, cs_rise_c, sck_rise_c, sck_fall_c;
    logic          start_c, pop_c, push_c, accept_c, word_nz_c;
    logic          cmd_load_c, err_inc_c;
    logic [31:0]   load_word_c;
    logic [CW-1:0] count_nxt_c;

    // A CS fall only counts once a genuine CS-high sample has passed the synchronizer
    // since reset, so a reset inside a CS-low period ignores the rest of that frame.
    assign cs_fall_c   = armed & cs_h & ~cs_s2;
    assign cs_rise_c   = ~cs_h & cs_s2;
    assign sck_rise_c  = ~sck_h & sck_s2 & ~cs_s2;
    assign sck_fall_c  = sck_h & ~sck_s2 & ~cs_s2;

    assign start_c     = (state == S_IDLE) & cs_fall_c;
    assign pop_c       = start_c & (count != '0);
    assign push_c      = bus.rsp_valid & ready_q;
    assign load_word_c = pop_c ? mem[rd_ptr] : 32'h0000_0000;
    assign count_nxt_c = count + CW'(push_c) - CW'(pop_c);

    assign accept_c    = cmd_valid_q & bus.cmd_ready;
    assign word_nz_c   = (rx_sr != 32'h0000_0000);
    assign cmd_load_c  = (state == S_END) & (bit_cnt == 6'd32) & word_nz_c
                         & (~cmd_valid_q | accept_c);
    assign err_inc_c   = (state == S_END)
                         & ((bit_cnt != 6'd32) | (word_nz_c & cmd_valid_q & ~accept_c));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cs_s1       <= 1'b1;
            cs_s2       <= 1'b1;
            cs_h        <= 1'b1;
            sck_s1      <= 1'b0;
            sck_s2      <= 1'b0;
            sck_h       <= 1'b0;
            mosi_s1     <= 1'b0;
            mosi_s2     <= 1'b0;
            rst_pipe    <= 2'b00;
            armed       <= 1'b0;
            bit_cnt     <= 6'd0;
            rx_sr       <= 32'h0000_0000;
            tx_sr       <= 32'h0000_0000;
            miso_q      <= 1'b0;
            cmd_data_q  <= 32'h0000_0000;
            cmd_valid_q <= 1'b0;
            err_q       <= 8'h00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ready_q     <= 1'b1;
        end else begin
            cs_s1    <= bus.spi_cs;
            cs_s2    <= cs_s1;
            sck_s1   <= bus.spi_sck;
            sck_s2   <= sck_s1;
            sck_h    <= sck_s2;
            mosi_s1  <= bus.spi_mosi;
            mosi_s2  <= mosi_s1;
            rst_pipe <= {rst_pipe[0], 1'b1};
            if (rst_pipe[1] && cs_s2)
                armed <= 1'b1;
            // Freezing the CS history during END keeps a CS fall pending for IDLE.
            if (state != S_END)
                cs_h <= cs_s2;

            case (state)
                S_IDLE: begin
                    if (cs_fall_c) begin
                        state   <= S_SHIFT;
                        bit_cnt <= 6'd0;
                        rx_sr   <= 32'h0000_0000;
                        tx_sr   <= load_word_c;
                        miso_q  <= load_word_c[31];
                    end
                end
                S_SHIFT: begin
                    if (sck_rise_c) begin
                        rx_sr <= {rx_sr[30:0], mosi_s2};
                        if (bit_cnt != 6'd63)
                            bit_cnt <= bit_cnt + 6'd1;
                    end
                    if (sck_fall_c) begin
                        tx_sr  <= {tx_sr[30:0], 1'b0};
                        miso_q <= tx_sr[30];
                    end
                    if (cs_rise_c)
                        state <= S_END;
                end
                S_END:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (cmd_load_c) begin
                cmd_data_q  <= rx_sr;
                cmd_valid_q <= 1'b1;
            end else if (accept_c) begin
                cmd_valid_q <= 1'b0;
            end

            if (err_inc_c && (err_q != 8'hFF))
                err_q <= err_q + 8'd1;

            if (push_c)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)
                rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt_c;
            ready_q <= (count_nxt_c != CW'(DEPTH));
        end
    end

    // Response storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_c)
            mem[wr_ptr] <= bus.rsp_data;
    end

    assign bus.spi_miso  = miso_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.rsp_ready = ready_q;
    assign bus.err_count = err_q;
endmodule

// File: doc/gigex_spi_slave.md
# gigex_spi_slave

Backend-side SPI slave that terminates the GigEx SPI port. It receives 32-bit command words from the host and hands each one to the backend command fabric over a valid/ready interface. It buffers 32-bit responses coming back from the fabric in a small FIFO and shifts the oldest one out to the host during the next SPI frame. All SPI pins are oversampled in the single system clock domain; the SPI clock is never used as a clock.

## Interface
- DEPTH, 16: response FIFO depth in words; must be a power of two and at least 2.
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- spi_cs  in  1  chip select, active low, asynchronous to clk.
- spi_sck  in  1  SPI clock, mode 0, idles low, asynchronous to clk.
- spi_mosi  in  1  host-to-slave data, MSB first.
- spi_miso  out  1  slave-to-host data, MSB first, registered.
- cmd_data  out  32  received command word.
- cmd_valid  out  1  cmd_data is valid; held until accepted.
- cmd_ready  in  1  fabric accepts cmd_data when cmd_valid and cmd_ready are both high.
- rsp_data  in  32  response word from the fabric.
- rsp_valid  in  1  rsp_data is valid.
- rsp_ready  out  1  FIFO not full; a word is pushed when rsp_valid and rsp_ready are both high.
- err_count  out  8  saturating count of frame errors.

## Operation
- Input sampling: spi_cs, spi_sck and spi_mosi each pass through a 2-flop synchronizer, followed by one history flop for edge detection. The sync stage resets cs to 1 and the other two to 0.
- The CS falling edge (synced) starts a frame:
  - The bit counter is cleared to 0.
  - If the FIFO is non-empty, the head word is loaded into the tx shift register and popped. Otherwise 32'h0000_0000 is loaded.
  - spi_miso is driven with bit 31 of the loaded word on the next clk.
- SCK rising edge (synced, CS low): mosi_sync is shifted into the LSB of the rx shift register. The bit counter increments and saturates at 63.
- SCK falling edge (synced, CS low): the tx register shifts left and spi_miso is updated with the new bit 31. Shifting past 32 bits shifts in zeros.
- The CS rising edge (synced) ends the frame:
  - bit count != 32: the word is discarded and err_count increments.
  - bit count == 32 and word == 0: this is a poll frame and is discarded silently.
  - bit count == 32, word != 0, and cmd_valid low: cmd_data is loaded with the word and cmd_valid is set.
  - bit count == 32, word != 0, and cmd_valid still high: the new word is dropped and err_count increments. The held word is not overwritten.
- cmd_valid clears on the cycle of acceptance (cmd_valid and cmd_ready both high). A new frame end in that same cycle loads normally, with no drop.
- err_count saturates at 8'hFF and clears only on rst.
- Response FIFO:
  - Occupancy range is 0..DEPTH; rsp_ready = (count != DEPTH).
  - A push and a pop in the same cycle both take effect. Count is unchanged and ordering is preserved. When the FIFO is empty, a push and a pop in the same cycle do not bypass: the frame loads 0 and the word is stored.
  - Pointers are log2(DEPTH) bits wide and wrap naturally.
- Frame state machine:
  - IDLE → SHIFT on CS fall.
  - SHIFT → END on CS rise.
  - END → IDLE after one cycle, during which the decision above is made.
  - A CS fall seen while in END is processed next cycle. The CS edge is held by the history flop.
- Reset values: spi_miso 0, cmd_valid 0, cmd_data 0, rsp_ready 1 (FIFO empty), err_count 0, state IDLE.
- Reset mid-frame: the frame is abandoned and nothing is forwarded. After release, the block waits for the next CS fall and ignores the remainder of the current CS-low period.

## Timing
- Synchronizer latency is 3 clk from a pin edge to edge detect.
- cmd_valid rises 4 clk after the spi_cs pin rises (3 sync plus 1 END).
- spi_miso updates at most 4 clk after the SCK pin falls. The host samples on the SCK falling edge of the following bit.
- Minimum SCK high and low time is 4 clk (40 ns). Minimum CS-high time between frames is 6 clk.
- FIFO push-to-available is 1 clk. A word pushed at least 1 clk before the synced CS fall is returned in that frame.
- rsp_ready is registered and updates 1 clk after the push or pop that changes fullness.

## Test plan
- Frame 32'hF064_04FF with cmd_ready=1 → one cmd_valid pulse with cmd_data=32'hF064_04FF, and err_count stays 0.
- Push rsp_data=32'h000A_BCDE, then send a frame of 32'h0 → the host reads 32'h000A_BCDE on spi_miso, cmd_valid stays low, and the FIFO becomes empty. The next poll returns 32'h0.
- 20-bit frame 0xF0640 → no cmd_valid and err_count=1. The following 32-bit frame 32'hF064_0011 is forwarded correctly.
- Hold cmd_ready=0 and send 32'hF064_0011 then 32'hF064_0010 → cmd_data stays 32'hF064_0011 and err_count=1. After cmd_ready=1 there is exactly one acceptance.
- Push DEPTH+1 words 1..17 with rsp_valid held high → rsp_ready falls after 16 pushes and word 17 is held off. A poll returns 1, rsp_ready rises, and word 17 is stored. Subsequent polls return 2..17 in order.
- Assert rst after 10 SCK bits of 32'hF064_0311, release it while CS is still low → no cmd_valid and spi_miso=0. The next complete frame 32'hF064_0311 is forwarded.
